key_control: RTL and testbench
==============================

// Module: key_control
// PURPOSE
//  Front-end for the LED blinker. Turns the four raw active-low board pushbuttons
//  into clean single-cycle command pulses: pause toggle, speed up/down and blinker
//  reset. Owns the 4-bit delay setting that feeds the blinker's delay input.
//  Per-key path: 2-flop synchronizer -> debounce FSM -> one-shot pulse.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  stable cycles required to accept a press/release (>=2; 10 ms @ 50 MHz)
//  CNT_W            20      debounce counter width; must hold DEBOUNCE_CYCLES-1
//  DELAY_INIT       4'd8    delay value after reset or blinker-reset command
//  DELAY_MIN        4'd1    lower saturation bound of delay
//  DELAY_MAX        4'd15   upper saturation bound of delay
// PORTS
//  clk          in   1  system clock
//  reset        in   1  asynchronous, active-high reset
//  key_n        in   4  raw pushbuttons, active-low, asynchronous to clk
//  pressed      out  4  debounced key level, 1 = held (bit i = key i)
//  pause        out  1  1-cycle pulse on accepted key0 press; drives blinker pause
//  blink_reset  out  1  1-cycle pulse on accepted key3 press; drives blinker reset
//  delay        out  4  current delay setting; drives blinker delay
// BEHAVIOUR
//  Reset (async, active-high): sync flops = 1 (released), all FSMs IDLE, counters 0,
//   pressed = 0, pause = 0, blink_reset = 0, delay = DELAY_INIT.
//  Synchronizer: key_n -> s1 -> s2; psync[i] = ~s2[i]. Nothing else samples key_n.
//  Debounce FSM per key, one CNT_W-bit counter each:
//   IDLE:    psync=1 -> PRESS_WAIT, cnt<=0.
//   PRESS_WAIT: psync=0 -> IDLE (bounce rejected, no pulse); else cnt==DEBOUNCE_CYCLES-1
//            -> HELD, fire one-shot; else cnt<=cnt+1.
//   HELD:    pressed[i]=1; psync=0 -> RELEASE_WAIT, cnt<=0.
//   RELEASE_WAIT: pressed[i]=1; psync=1 -> HELD (no new pulse); else cnt==DEBOUNCE_CYCLES-1
//            -> IDLE; else cnt<=cnt+1.
//  pressed[i] registered: 1 in HELD and RELEASE_WAIT, 0 otherwise.
//  Latency: key_n low and stable from before edge 1 -> one-shot high for exactly the cycle
//   after edge DEBOUNCE_CYCLES+3. Holding a key never repeats the pulse.
//  Key map: key0 -> pause; key1 -> up (delay+1); key2 -> down (delay-1); key3 -> blink_reset.
//  pause and blink_reset are registered one-shots: high exactly one cycle, no gaps/merges.
//  Delay register, updated on the edge after the internal one-shot (same cycle pause fires):
//   key3 pulse: delay <= DELAY_INIT; takes priority over up/down in same cycle.
//   up and down in same cycle: no change.
//   up alone: delay+1 if delay<DELAY_MAX else hold (saturate, never wrap 15->0).
//   down alone: delay-1 if delay>DELAY_MIN else hold (never reaches 0).
//  Keys are independent; simultaneous pulses on different keys all take effect.
//  Reset mid-debounce: FSM returns IDLE, pending pulse discarded; a key still held at
//   reset release is re-debounced from scratch and pulses once when accepted.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, CNT_W=3)
//  1 Reset, hold key_n=4'b1111 -> pressed=0, pause=0, blink_reset=0, delay=8 for 50 cycles.
//  2 key_n[0] low at cycle 0, held 30 cycles -> pause high only in cycle after edge 7;
//    pressed[0]=1 from then until 4 stable released cycles after release.
//  3 key_n[1] glitches low 2 cycles then high -> no state change, delay stays 8, no pulse.
//  4 Eight key1 presses from delay=8 -> delay 9..15 then holds 15; 15 key2 presses -> holds 1.
//  5 key1 and key2 pressed on same cycle -> both accepted together, delay unchanged;
//    key3 with key1 -> blink_reset pulse, delay=8.
//  6 Assert reset during PRESS_WAIT of key0 -> no pause pulse; key still held after
//    release of reset -> exactly one pause pulse DEBOUNCE_CYCLES+3 edges later.

Source files
------------

// File: rtl/key_control.sv
// ---------------------------------------------------------------------------
// key_control
//   Front-end for the LED blinker. Cleans up the four raw active-low board
//   pushbuttons and turns accepted presses into single-cycle commands, and
//   owns the 4-bit delay setting consumed by the blinker.
//
//   Per key: 2-flop synchronizer -> debounce FSM -> registered one-shot.
//   key0 -> pause, key1 -> delay up, key2 -> delay down, key3 -> blink_reset.
//
//   There is no valid/ready handshake here. Every command is a plain one-cycle
//   strobe that the blinker must act on in the cycle it is high.
//
//   The debounce FSM state of every key is held in key_state[0..3]. It is kept
//   as a named array so checkers can bind to it.
//
// Ports
//   clk          in   1  system clock
//   reset        in   1  asynchronous, active-high reset
//   key_n        in   4  raw pushbuttons, active-low, asynchronous to clk
//   pressed      out  4  debounced key level, 1 = held (bit i = key i)
//   pause        out  1  1-cycle pulse on accepted key0 press
//   blink_reset  out  1  1-cycle pulse on accepted key3 press
//   delay        out  4  current delay setting for the blinker
// ---------------------------------------------------------------------------
module key_control #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20,
    parameter logic [3:0]  DELAY_INIT      = 4'd8,
    parameter logic [3:0]  DELAY_MIN       = 4'd1,
    parameter logic [3:0]  DELAY_MAX       = 4'd15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_n,
    output logic [3:0] pressed,
    output logic       pause,
    output logic       blink_reset,
    output logic [3:0] delay
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       s1;
    logic [3:0]       s2;
    logic [3:0]       psync;
    logic [3:0]       pulse;
    key_state_t       key_state [4];
    logic [CNT_W-1:0] cnt       [4];

    // Sync flops reset to 1 (released), so a key held through reset is seen
    // as a fresh press once reset drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 4'hF;
            s2 <= 4'hF;
        end else begin
            s1 <= key_n;
            s2 <= s1;
        end
    end

    assign psync = ~s2;

    // Debounce FSMs. A level must persist while the counter walks from 0 to
    // CNT_LAST before it is accepted. Any bounce back drops to the previous
    // stable state without a pulse. pressed and pulse are written only on
    // transitions, so they stay registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                key_state[i] <= IDLE;
                cnt[i]       <= '0;
            end
            pressed <= 4'b0000;
            pulse   <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                pulse[i] <= 1'b0;
                case (key_state[i])
                    IDLE: begin
                        if (psync[i]) begin
                            key_state[i] <= PRESS_WAIT;
                            cnt[i]       <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!psync[i]) begin
                            key_state[i] <= IDLE;
                        end else if (cnt[i] == CNT_LAST) begin
                            key_state[i] <= HELD;
                            pressed[i]   <= 1'b1;
                            pulse[i]     <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                    HELD: begin
                        if (!psync[i]) begin
                            key_state[i] <= RELEASE_WAIT;
                            cnt[i]       <= '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (psync[i]) begin
                            key_state[i] <= HELD;
                        end else if (cnt[i] == CNT_LAST) begin
                            key_state[i] <= IDLE;
                            pressed[i]   <= 1'b0;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                    default: begin
                        key_state[i] <= IDLE;
                    end
                endcase
            end
        end
    end

    assign pause       = pulse[0];
    assign blink_reset = pulse[3];

    // Delay setting. A blinker reset overrides up and down. Up and down in the
    // same cycle cancel each other. The value saturates at both ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            delay <= DELAY_INIT;
        end else if (pulse[3]) begin
            delay <= DELAY_INIT;
        end else if (pulse[1] && !pulse[2]) begin
            if (delay < DELAY_MAX) begin
                delay <= delay + 4'd1;
            end
        end else if (pulse[2] && !pulse[1]) begin
            if (delay > DELAY_MIN) begin
                delay <= delay - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_key_control.sv
module tb_key_control;

    localparam int DEB = 4;

    logic       clk;
    logic       reset;
    logic [3:0] key_n;
    logic [3:0] pressed;
    logic       pause;
    logic       blink_reset;
    logic [3:0] delay;

    int n_cmp = 0;
    int n_bad = 0;

    key_control #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (3),
        .DELAY_INIT     (4'd8),
        .DELAY_MIN      (4'd1),
        .DELAY_MAX      (4'd15)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_n      (key_n),
        .pressed    (pressed),
        .pause      (pause),
        .blink_reset(blink_reset),
        .delay      (delay)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each key is accepted once its synchronized level has disagreed with the
    // accepted level on DEB+1 consecutive clock edges. Any agreement restarts
    // the run. Commands take effect on the edge after their pulse.
    logic [3:0] m_s1, m_s2, m_acc, m_pulse;
    int         m_run [4];
    int         m_delay;

    task automatic model_reset();
        m_s1    = 4'hF;
        m_s2    = 4'hF;
        m_acc   = 4'h0;
        m_pulse = 4'h0;
        m_delay = 8;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
    endtask

    task automatic model_step(input logic [3:0] kn);
        int d;
        if (m_pulse[3]) begin
            m_delay = 8;
        end else begin
            d = m_delay + int'(m_pulse[1]) - int'(m_pulse[2]);
            if (d > 15) d = 15;
            if (d < 1) d = 1;
            m_delay = d;
        end
        m_pulse = 4'h0;
        for (int i = 0; i < 4; i++) begin
            if (!m_s2[i] != m_acc[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB + 1) begin
                    m_acc[i]   = ~m_acc[i];
                    m_run[i]   = 0;
                    m_pulse[i] = m_acc[i];
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = kn;
    endtask

    // Step the model on each rising edge and compare the outputs on the falling edge.
    initial begin
        logic [3:0] kn;
        model_reset();
        forever begin
            @(posedge clk);
            kn = key_n;
            if (!reset) model_step(kn);
            @(negedge clk);
            if (reset) model_reset();
            check("pressed", pressed, m_acc);
            check("pause", {3'b0, pause}, {3'b0, m_pulse[0]});
            check("blink_reset", {3'b0, blink_reset}, {3'b0, m_pulse[3]});
            check("delay", delay, m_delay[3:0]);
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change 2 time units after a rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Hold the keys in mask for 10 edges, then release for 12 edges.
    // The outputs seen 7 edges into the hold are returned.
    task automatic press(input logic [3:0] mask, output logic p7, output logic b7);
        key_n = ~mask;
        repeat (7) tick();
        p7 = pause;
        b7 = blink_reset;
        repeat (3) tick();
        key_n = 4'hF;
        repeat (12) tick();
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic p7, b7;
        reset = 1'b1;
        key_n = 4'hF;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;

        // 1: idle after reset
        repeat (50) tick();
        check("idle_delay", delay, 4'd8);
        check("idle_pressed", pressed, 4'd0);

        // 2: key0 held for 30 edges. pause is high only after edge 7.
        key_n = 4'b1110;
        repeat (6) tick();
        check("k0_pause_e6", {3'b0, pause}, 4'd0);
        tick();
        check("k0_pause_e7", {3'b0, pause}, 4'd1);
        check("k0_pressed_e7", pressed, 4'b0001);
        tick();
        check("k0_pause_e8", {3'b0, pause}, 4'd0);
        repeat (22) tick();
        check("k0_hold", pressed, 4'b0001);
        key_n = 4'hF;
        repeat (6) tick();
        check("k0_rel_e6", pressed, 4'b0001);
        tick();
        check("k0_rel_e7", pressed, 4'b0000);
        repeat (10) tick();

        // 3: a 2-edge glitch on key1 is rejected
        key_n = 4'b1101;
        repeat (2) tick();
        key_n = 4'hF;
        repeat (12) tick();
        check("glitch_pressed", pressed, 4'd0);
        check("glitch_delay", delay, 4'd8);

        // 4: delay saturates at 15 going up and at 1 going down
        for (int i = 0; i < 8; i++) begin
            press(4'b0010, p7, b7);
            if (i == 0) check("up_first", delay, 4'd9);
        end
        check("up_sat", delay, 4'd15);
        for (int i = 0; i < 15; i++) press(4'b0100, p7, b7);
        check("down_sat", delay, 4'd1);

        // 5: up and down together cancel. key3 overrides key1.
        press(4'b0010, p7, b7);
        check("up_from_1", delay, 4'd2);
        press(4'b0110, p7, b7);
        check("up_down_same", delay, 4'd2);
        press(4'b1010, p7, b7);
        check("k3k1_blink", {3'b0, b7}, 4'd1);
        check("k3k1_delay", delay, 4'd8);

        // 6: reset during PRESS_WAIT. The held key pulses once after reset drops.
        key_n = 4'b1110;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check("rst_pause", {3'b0, pause}, 4'd0);
        check("rst_pressed", pressed, 4'd0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (6) tick();
        check("rst_pause_e6", {3'b0, pause}, 4'd0);
        tick();
        check("rst_pause_e7", {3'b0, pause}, 4'd1);
        tick();
        check("rst_pause_e8", {3'b0, pause}, 4'd0);
        repeat (10) tick();
        key_n = 4'hF;
        repeat (12) tick();

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
